// File: rtl/exec_stage_p.sv
// rtl/exec_stage_p.sv - execute stage: ALU/NZCV, conditional branch with flush window, multi-cycle MUL with stall
module exec_stage_p #(
    parameter int DATA_W       = 32,
    parameter int NREGS        = 16,
    parameter int MUL_CYCLES   = 4,
    parameter int FLUSH_CYCLES = 2,
    localparam int SEL_W       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              num_to_rhs,
    input  logic [DATA_W-1:0] num,
    input  logic [SEL_W-1:0]  sel_p0,
    input  logic [SEL_W-1:0]  sel_p1,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [4:0]        uop,
    input  logic [3:0]        branch_cond,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [3:0]        flags,
    output logic              stall,
    output logic              global_disable,
    output logic [DATA_W-1:0] delta_instruction
);

    localparam logic [4:0] U_ADD = 5'd1;
    localparam logic [4:0] U_SUB = 5'd2;
    localparam logic [4:0] U_AND = 5'd3;
    localparam logic [4:0] U_ORR = 5'd4;
    localparam logic [4:0] U_CMP = 5'd5;
    localparam logic [4:0] U_EOR = 5'd6;
    localparam logic [4:0] U_MOV = 5'd8;
    localparam logic [4:0] U_MUL = 5'd9;
    localparam logic [4:0] U_B   = 5'd10;

    // One down-counter serves both the MUL and FLUSH states, so size it for the longer one.
    localparam int CNT_MAX = (MUL_CYCLES > FLUSH_CYCLES) ? MUL_CYCLES : FLUSH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    // Counter ends at zero on the last cycle of the state, hence the -2 / -1 loads.
    localparam logic [CNT_W-1:0] MUL_LOAD   = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FLUSH} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   regs [NREGS];
    logic [DATA_W-1:0]   mul_a, mul_b;
    logic [SEL_W-1:0]    mul_dst;

    logic [DATA_W-1:0]   lhs, rhs;
    logic [DATA_W:0]     add_full, sub_full;
    logic                add_v, sub_v;
    logic [DATA_W-1:0]   logic_res;
    logic [DATA_W-1:0]   mul_now, mul_res;
    logic                cond_hit;

    logic                wr_en;
    logic [SEL_W-1:0]    wr_sel;
    logic [DATA_W-1:0]   wr_data;
    logic [3:0]          flags_nxt;
    logic                mul_cap;
    logic [DATA_W-1:0]   delta_nxt;

    // ARM condition evaluation on {N,Z,C,V}; code 15 is never taken.
    function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:    cond_eval = z;
            4'd1:    cond_eval = !z;
            4'd2:    cond_eval = c;
            4'd3:    cond_eval = !c;
            4'd4:    cond_eval = n;
            4'd5:    cond_eval = !n;
            4'd6:    cond_eval = v;
            4'd7:    cond_eval = !v;
            4'd8:    cond_eval = c && !z;
            4'd9:    cond_eval = !c || z;
            4'd10:   cond_eval = (n == v);
            4'd11:   cond_eval = (n != v);
            4'd12:   cond_eval = !z && (n == v);
            4'd13:   cond_eval = z || (n != v);
            4'd14:   cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    assign lhs       = regs[sel_p0];
    assign rhs       = num_to_rhs ? num : regs[sel_p1];
    assign add_full  = {1'b0, lhs} + {1'b0, rhs};
    // Subtract as lhs + ~rhs + 1 so the carry out is directly NOT borrow.
    assign sub_full  = {1'b0, lhs} + {1'b0, ~rhs} + {{DATA_W{1'b0}}, 1'b1};
    assign add_v     = (lhs[DATA_W-1] == rhs[DATA_W-1]) && (add_full[DATA_W-1] != lhs[DATA_W-1]);
    assign sub_v     = (lhs[DATA_W-1] != rhs[DATA_W-1]) && (sub_full[DATA_W-1] != lhs[DATA_W-1]);
    assign logic_res = (uop == U_AND) ? (lhs & rhs) : (uop == U_ORR) ? (lhs | rhs) : (lhs ^ rhs);
    assign mul_now   = lhs * rhs;
    assign mul_res   = mul_a * mul_b;
    assign cond_hit  = cond_eval(branch_cond, flags);
    assign dbg_data  = regs[dbg_sel];

    // State register and shared cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: MUL and taken B leave IDLE; MUL/FLUSH return when the counter hits zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (uop == U_MUL && MUL_CYCLES > 1) begin
                    state_nxt = S_MUL;
                    cnt_nxt   = MUL_LOAD;
                end else if (uop == U_B && cond_hit) begin
                    state_nxt = S_FLUSH;
                    cnt_nxt   = FLUSH_LOAD;
                end
            end
            S_MUL, S_FLUSH: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath control: register/flag writes, MUL operand capture and branch delta.
    always_comb begin
        wr_en     = 1'b0;
        wr_sel    = sel_in;
        wr_data   = '0;
        flags_nxt = flags;
        mul_cap   = 1'b0;
        delta_nxt = '0;
        case (state)
            S_IDLE: begin
                case (uop)
                    U_ADD: begin
                        wr_en     = 1'b1;
                        wr_data   = add_full[DATA_W-1:0];
                        flags_nxt = {add_full[DATA_W-1], add_full[DATA_W-1:0] == '0, add_full[DATA_W], add_v};
                    end
                    U_SUB: begin
                        wr_en     = 1'b1;
                        wr_data   = sub_full[DATA_W-1:0];
                        flags_nxt = {sub_full[DATA_W-1], sub_full[DATA_W-1:0] == '0, sub_full[DATA_W], sub_v};
                    end
                    U_CMP: begin
                        flags_nxt = {sub_full[DATA_W-1], sub_full[DATA_W-1:0] == '0, sub_full[DATA_W], sub_v};
                    end
                    U_AND, U_ORR, U_EOR: begin
                        wr_en     = 1'b1;
                        wr_data   = logic_res;
                        flags_nxt = {logic_res[DATA_W-1], logic_res == '0, flags[1:0]};
                    end
                    U_MOV: begin
                        wr_en   = 1'b1;
                        wr_data = num_to_rhs ? num : lhs;
                    end
                    U_MUL: begin
                        if (MUL_CYCLES == 1) begin
                            wr_en   = 1'b1;
                            wr_data = mul_now;
                        end else begin
                            mul_cap = 1'b1;
                        end
                    end
                    U_B: begin
                        if (cond_hit) delta_nxt = num;
                    end
                    default: ;
                endcase
            end
            S_MUL: begin
                if (cnt == '0) begin
                    wr_en   = 1'b1;
                    wr_sel  = mul_dst;
                    wr_data = mul_res;
                end
            end
            default: ;
        endcase
    end

    // Register file and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            flags <= 4'b0;
        end else begin
            if (wr_en) regs[wr_sel] <= wr_data;
            flags <= flags_nxt;
        end
    end

    // MUL operands and destination are frozen at acceptance so upstream inputs may change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a   <= '0;
            mul_b   <= '0;
            mul_dst <= '0;
        end else if (mul_cap) begin
            mul_a   <= lhs;
            mul_b   <= rhs;
            mul_dst <= sel_in;
        end
    end

    // Registered pipeline-control outputs, derived from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall             <= 1'b0;
            global_disable    <= 1'b0;
            delta_instruction <= '0;
        end else begin
            stall             <= (state_nxt == S_MUL);
            global_disable    <= (state_nxt == S_FLUSH);
            delta_instruction <= delta_nxt;
        end
    end

endmodule

// File: tb/tb_exec_stage_p.sv
// tb/tb_exec_stage_p.sv - self-checking bench for exec_stage_p with a behavioural reference model
module tb_exec_stage_p;

    localparam int MC = 4;
    localparam int FC = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, num_to_rhs;
    logic [31:0] num;
    logic [3:0]  sel_p0, sel_p1, sel_in, dbg_sel;
    logic [4:0]  uop;
    logic [3:0]  branch_cond;
    logic [31:0] dbg_data, delta_instruction;
    logic [3:0]  flags;
    logic        stall, global_disable;

    logic        s_rst_n, s_num_to_rhs;
    logic [15:0] s_num, s_dbg_data, s_delta;
    logic [2:0]  s_sel_p0, s_sel_p1, s_sel_in, s_dbg_sel;
    logic [4:0]  s_uop;
    logic [3:0]  s_branch_cond, s_flags;
    logic        s_stall, s_gd;

    exec_stage_p #(.DATA_W(32), .NREGS(16), .MUL_CYCLES(MC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .num_to_rhs(num_to_rhs), .num(num),
        .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in), .uop(uop),
        .branch_cond(branch_cond), .dbg_sel(dbg_sel), .dbg_data(dbg_data),
        .flags(flags), .stall(stall), .global_disable(global_disable),
        .delta_instruction(delta_instruction)
    );

    exec_stage_p #(.DATA_W(16), .NREGS(8), .MUL_CYCLES(MC), .FLUSH_CYCLES(FC)) dut16 (
        .clk(clk), .rst_n(s_rst_n), .num_to_rhs(s_num_to_rhs), .num(s_num),
        .sel_p0(s_sel_p0), .sel_p1(s_sel_p1), .sel_in(s_sel_in), .uop(s_uop),
        .branch_cond(s_branch_cond), .dbg_sel(s_dbg_sel), .dbg_data(s_dbg_data),
        .flags(s_flags), .stall(s_stall), .global_disable(s_gd),
        .delta_instruction(s_delta)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural state plus "cycles still blocked" counters.
    logic [31:0] m_regs [16];
    logic [3:0]  m_flags;
    int          mul_left, flush_left, mul_dst;
    logic [31:0] mul_val, exp_delta;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc)
            0: return z;           1: return !z;
            2: return c;           3: return !c;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return c && !z;     9: return !c || z;
            10: return n == v;     11: return n != v;
            12: return !z && n == v;
            13: return z || n != v;
            14: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 0;
        m_flags = 0; mul_left = 0; flush_left = 0; exp_delta = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently presented.
    task automatic model_edge();
        logic [31:0] a, b, r;
        longint ua, ub, sa, sb, s, hi, lo;
        hi = 64'sd2147483647; lo = -hi - 1;
        exp_delta = 0;
        if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) m_regs[mul_dst] = mul_val;
        end else if (flush_left > 0) begin
            flush_left--;
        end else begin
            a = m_regs[sel_p0];
            b = num_to_rhs ? num : m_regs[sel_p1];
            ua = a; ub = b;
            sa = longint'($signed(a)); sb = longint'($signed(b));
            case (uop)
                1: begin
                    r = a + b; s = sa + sb; m_regs[sel_in] = r;
                    m_flags = {r[31], r == 0, (ua + ub) > 64'd4294967295, s > hi || s < lo};
                end
                2, 5: begin
                    r = a - b; s = sa - sb;
                    if (uop == 2) m_regs[sel_in] = r;
                    m_flags = {r[31], r == 0, ua >= ub, s > hi || s < lo};
                end
                3, 4, 6: begin
                    r = (uop == 3) ? (a & b) : (uop == 4) ? (a | b) : (a ^ b);
                    m_regs[sel_in] = r;
                    m_flags = {r[31], r == 0, m_flags[1:0]};
                end
                8: m_regs[sel_in] = num_to_rhs ? num : a;
                9: begin
                    r = 32'(ua * ub);
                    if (MC == 1) m_regs[sel_in] = r;
                    else begin mul_left = MC - 1; mul_val = r; mul_dst = int'(sel_in); end
                end
                10: if (cond_ok(branch_cond, m_flags)) begin
                    exp_delta = num; flush_left = FC;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp);
        dbg_sel = 4'(idx);
        #1;
        check(tag, dbg_data, exp);
    endtask

    // One clock: model, edge, compare all registered outputs plus one random register.
    task automatic step();
        int k;
        model_edge();
        @(posedge clk);
        #1;
        check("stall", 32'(stall), 32'(mul_left > 0));
        check("global_disable", 32'(global_disable), 32'(flush_left > 0));
        check("delta_instruction", delta_instruction, exp_delta);
        check("flags", 32'(flags), 32'(m_flags));
        k = $urandom_range(0, 15);
        chk_reg("dbg_rand", k, m_regs[k]);
    endtask

    task automatic issue(input logic [4:0] u, input int d, input int p0, input int p1,
                         input logic nr, input logic [31:0] n, input logic [3:0] cc);
        uop = u; sel_in = 4'(d); sel_p0 = 4'(p0); sel_p1 = 4'(p1);
        num_to_rhs = nr; num = n; branch_cond = cc;
        step();
    endtask

    task automatic s_issue(input logic [4:0] u, input int d, input int p0, input logic [15:0] n);
        s_uop = u; s_sel_in = 3'(d); s_sel_p0 = 3'(p0); s_sel_p1 = 3'd0;
        s_num_to_rhs = 1'b1; s_num = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nstall;
        logic [4:0] ops [12];
        ops = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9, 5'd10, 5'd0, 5'd7, 5'd20};

        rst_n = 0; s_rst_n = 0;
        num_to_rhs = 0; num = 0; sel_p0 = 0; sel_p1 = 0; sel_in = 0; uop = 0;
        branch_cond = 0; dbg_sel = 0;
        s_num_to_rhs = 0; s_num = 0; s_sel_p0 = 0; s_sel_p1 = 0; s_sel_in = 0;
        s_uop = 0; s_branch_cond = 0; s_dbg_sel = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check("rst_stall", 32'(stall), 0);
        check("rst_gd", 32'(global_disable), 0);
        check("rst_delta", delta_instruction, 0);
        check("rst_flags", 32'(flags), 0);
        for (int i = 0; i < 16; i++) chk_reg("rst_reg", i, 0);
        rst_n = 1; s_rst_n = 1;

        // ALU sequence
        issue(5'd8, 1, 0, 0, 1, 32'h0000CAFE, 0);
        issue(5'd8, 2, 1, 0, 0, 32'h0, 0);
        issue(5'd1, 3, 1, 2, 0, 32'h0, 0);
        issue(5'd3, 2, 2, 3, 0, 32'h0, 0);
        chk_reg("r1_cafe", 1, 32'h0000CAFE);
        chk_reg("r2_and", 2, 32'h000080FC);
        chk_reg("r3_add", 3, 32'h000195FC);
        check("and_nz", 32'(flags[3:2]), 0);

        // CMP then taken BLT, ADDs inside the flush window are discarded
        issue(5'd5, 0, 2, 3, 0, 32'h0, 0);
        check("cmp_flags", 32'(flags), 32'b1000);
        issue(5'd10, 0, 0, 0, 0, 32'hFFFFFFFD, 4'd11);
        check("blt_delta", delta_instruction, 32'hFFFFFFFD);
        check("blt_gd1", 32'(global_disable), 1);
        issue(5'd1, 1, 1, 1, 0, 32'h0, 0);
        check("blt_delta_once", delta_instruction, 0);
        check("blt_gd2", 32'(global_disable), 1);
        issue(5'd1, 1, 1, 1, 0, 32'h0, 0);
        check("blt_gd_end", 32'(global_disable), 0);
        chk_reg("flush_no_write", 1, 32'h0000CAFE);

        // CMP equal then BNE not taken
        issue(5'd5, 0, 1, 1, 0, 32'h0, 0);
        check("cmp_eq_flags", 32'(flags), 32'b0110);
        issue(5'd10, 0, 0, 0, 0, 32'h00000010, 4'd1);
        check("bne_delta", delta_instruction, 0);
        check("bne_gd", 32'(global_disable), 0);

        // MUL with a MOV held during the stall
        issue(5'd8, 1, 0, 0, 1, 32'd7, 0);
        issue(5'd8, 2, 0, 0, 1, 32'd6, 0);
        issue(5'd8, 5, 0, 0, 1, 32'd0, 0);
        issue(5'd9, 4, 1, 2, 0, 32'h0, 0);
        nstall = int'(stall);
        for (int i = 0; i < 3; i++) begin
            issue(5'd8, 5, 0, 0, 1, 32'd5, 0);
            nstall += int'(stall);
            if (i == 0) chk_reg("mov_held", 5, 0);
        end
        check("mul_stall_cycles", 32'(nstall), 3);
        chk_reg("mul_r4", 4, 32'd42);
        issue(5'd8, 5, 0, 0, 1, 32'd5, 0);
        chk_reg("mov_after_mul", 5, 32'd5);
        check("mov_after_stall", 32'(stall), 0);

        // Reset pulse in the second MUL cycle
        issue(5'd9, 7, 1, 2, 0, 32'h0, 0);
        issue(5'd0, 0, 0, 0, 0, 32'h0, 0);
        #2 rst_n = 0;
        #1;
        check("rst_mul_stall", 32'(stall), 0);
        check("rst_mul_flags", 32'(flags), 0);
        chk_reg("rst_mul_r4", 4, 0);
        rst_n = 1;
        model_reset();
        issue(5'd8, 6, 0, 0, 1, 32'd3, 0);
        chk_reg("post_rst_mov", 6, 32'd3);
        chk_reg("post_rst_r7", 7, 0);

        // 16-bit / 8-register instance
        uop = 0;
        s_issue(5'd8, 1, 0, 16'hFFFF);
        s_issue(5'd1, 2, 1, 16'h0001);
        s_dbg_sel = 3'd2; #1;
        check("w16_r2", 32'(s_dbg_data), 0);
        check("w16_wrap_flags", 32'(s_flags), 32'b0110);
        s_issue(5'd8, 3, 0, 16'h7FFF);
        s_issue(5'd1, 4, 3, 16'h0001);
        s_dbg_sel = 3'd4; #1;
        check("w16_r4", 32'(s_dbg_data), 32'h8000);
        check("w16_ovf_flags", 32'(s_flags), 32'b1001);

        // Randomized instruction stream against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] n;
            n = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            issue(ops[$urandom_range(0, 11)], $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), 1'($urandom), n, 4'($urandom));
        end
        for (int i = 0; i < 6; i++) issue(5'd0, 0, 0, 0, 0, 32'h0, 0);
        for (int i = 0; i < 16; i++) chk_reg("final_reg", i, m_regs[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
